// File: rtl/tb_status_periph.sv
// -----------------------------------------------------------------------------
// tb_status_periph
//
// Memory-mapped testbench status peripheral. Firmware writes stdout characters,
// an exit code and a pass/fail magic word. This block turns them into the
// inputs of the top-level pass/fail/exit checker. Characters are buffered in a
// small FIFO that a print consumer drains.
//
// Register map (offset = addr_i[4:2]):
//   0 PRINT       (W) push wdata_i[7:0] when be_i[0]
//   1 EXIT        (W) first write latches the exit code and sets exit_valid_o
//   2 TEST_STATUS (W) PASS_MAGIC / FAIL_MAGIC set the sticky pass/fail flag
//   3 CHAR_COUNT  (R) count of characters accepted into the FIFO
//   4 FIFO_LEVEL  (R) current FIFO occupancy
//   5 CYCLES      (R) cycle counter value (0 without TB_STATUS_CYCLE_COUNTER_EN)
//
// Optional feature macro: TB_STATUS_CYCLE_COUNTER_EN
//   When defined, a 32-bit free-running cycle counter exists. It freezes once
//   any of exit_valid_o, tests_passed_o or tests_failed_o is set.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i/addr_i/we_i/be_i/wdata_i   bus request (already window-selected)
//   gnt_o               combinational grant; low only for PRINT to a full FIFO
//   rvalid_o/rdata_o    response one cycle after grant
//   print_valid_o/print_char_o/print_ready_i   FIFO head to print consumer
//   tests_passed_o/tests_failed_o/exit_valid_o/exit_value_o   checker inputs
// -----------------------------------------------------------------------------
module tb_status_periph #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        print_valid_o,
  output logic [7:0]  print_char_o,
  input  logic        print_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [2:0] OFF_PRINT  = 3'd0;
  localparam logic [2:0] OFF_EXIT   = 3'd1;
  localparam logic [2:0] OFF_TEST   = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_LEVEL  = 3'd4;
  localparam logic [2:0] OFF_CYCLES = 3'd5;

  // State flops
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   char_count_q, char_count_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          passed_q, passed_d;
  logic          failed_q, failed_d;
  logic          exit_valid_q, exit_valid_d;
  logic [31:0]   exit_value_q, exit_value_d;
`ifdef TB_STATUS_CYCLE_COUNTER_EN
  logic [31:0]   cycles_q, cycles_d;
`endif

  // Decode signals
  logic [2:0]    offset_s;
  logic [PW-1:0] level_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          gnt_s;
  logic          wr_s;
  logic          rd_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   rd_mux_s;
  logic          unused_s;

  // Address bits outside [4:2] and upper byte enables carry no meaning here.
  assign unused_s = ^{addr_i[31:5], addr_i[1:0], be_i[3:1]};

  // Bus decode, FIFO status and grant
  always_comb begin
    offset_s     = addr_i[4:2];
    // Pointers carry one extra wrap bit, so the difference is the occupancy.
    level_s      = wr_ptr_q - rd_ptr_q;
    fifo_full_s  = (level_s == PW'(FIFO_DEPTH));
    fifo_empty_s = (level_s == {PW{1'b0}});
    // Full is taken from registered pointers, so a same-cycle pop does not
    // release a stalled PRINT; it is granted on the following cycle.
    gnt_s  = req_i & ~(we_i & (offset_s == OFF_PRINT) & be_i[0] & fifo_full_s);
    wr_s   = gnt_s & we_i;
    rd_s   = gnt_s & ~we_i;
    push_s = wr_s & (offset_s == OFF_PRINT) & be_i[0];
    pop_s  = ~fifo_empty_s & print_ready_i;
  end

  // Read data multiplexer, sampled at grant
  always_comb begin
    rd_mux_s = 32'd0;
    case (offset_s)
      OFF_COUNT:  rd_mux_s = char_count_q;
      OFF_LEVEL:  rd_mux_s = {{(32-PW){1'b0}}, level_s};
`ifdef TB_STATUS_CYCLE_COUNTER_EN
      OFF_CYCLES: rd_mux_s = cycles_q;
`else
      OFF_CYCLES: rd_mux_s = 32'd0;
`endif
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Next-state logic for FIFO, counters, flags and bus response
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    char_count_d = char_count_q;
    passed_d     = passed_q;
    failed_d     = failed_q;
    exit_valid_d = exit_valid_q;
    exit_value_d = exit_value_q;
    rvalid_d     = gnt_s;
    rdata_d      = rd_s ? rd_mux_s : 32'd0;

    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata_i[7:0];
      wr_ptr_d     = wr_ptr_q + PW'(1'b1);
      char_count_d = char_count_q + 32'd1;
    end else begin
      wr_ptr_d     = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Exit code is captured once; later writes are ignored.
    if (wr_s && (offset_s == OFF_EXIT) && !exit_valid_q) begin
      exit_valid_d = 1'b1;
      exit_value_d = wdata_i;
    end else begin
      exit_valid_d = exit_valid_q;
    end

    // First recognised magic wins; afterwards the register is locked.
    if (wr_s && (offset_s == OFF_TEST) && !passed_q && !failed_q) begin
      if (wdata_i == PASS_MAGIC) begin
        passed_d = 1'b1;
      end else if (wdata_i == FAIL_MAGIC) begin
        failed_d = 1'b1;
      end else begin
        passed_d = passed_q;
      end
    end else begin
      passed_d = passed_q;
    end
  end

`ifdef TB_STATUS_CYCLE_COUNTER_EN
  // Cycle counter runs until the test reports an outcome, then holds
  always_comb begin
    if (exit_valid_q || passed_q || failed_q) begin
      cycles_d = cycles_q;
    end else begin
      cycles_d = cycles_q + 32'd1;
    end
  end
`endif

  // State register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'd0;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      char_count_q <= 32'd0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= 32'd0;
`ifdef TB_STATUS_CYCLE_COUNTER_EN
      cycles_q     <= 32'd0;
`endif
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      char_count_q <= char_count_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
`ifdef TB_STATUS_CYCLE_COUNTER_EN
      cycles_q     <= cycles_d;
`endif
    end
  end

  assign gnt_o          = gnt_s;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign print_valid_o  = ~fifo_empty_s;
  assign print_char_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule
